// File: rtl/alu_iterative_exec.sv
// EX-stage execution unit: single-cycle logic/add/sub/compare, iterative
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_iterative_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] SEL_NOP = 3'b000;
  localparam logic [2:0] SEL_AND = 3'b001;
  localparam logic [2:0] SEL_OR  = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b011;
  localparam logic [2:0] SEL_MUL = 3'b100;
  localparam logic [2:0] SEL_DIV = 3'b101;
  localparam logic [2:0] SEL_ADD = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;    // MUL partial product / DIV remainder
  logic [WIDTH-1:0]  opa_q, opa_d;    // MUL multiplicand / DIV dividend->quotient
  logic [WIDTH-1:0]  opb_q, opb_d;    // MUL multiplier / DIV divisor
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;
  logic              dbz_q, dbz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  alu_s;
  logic              slt_s;
  logic [WIDTH-1:0]  mul_sum_s;
  logic [WIDTH:0]    rem_shift_s;
  logic [WIDTH:0]    rem_diff_s;
  logic              div_ge_s;
  logic [WIDTH-1:0]  rem_next_s;
  logic [WIDTH-1:0]  quot_next_s;

  assign mul_sum_s   = acc_q + (opb_q[0] ? opa_q : {WIDTH{1'b0}});
  assign rem_shift_s = {acc_q, opa_q[WIDTH-1]};
  assign rem_diff_s  = rem_shift_s - {1'b0, opb_q};
  assign div_ge_s    = ~rem_diff_s[WIDTH];
  assign rem_next_s  = div_ge_s ? rem_diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
  assign quot_next_s = {opa_q[WIDTH-2:0], div_ge_s};
  assign slt_s       = ($signed(a) < $signed(b));

  // Single-cycle ALU result from the live operands at accept.
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (sel)
      SEL_AND: alu_s = a & b;
      SEL_OR:  alu_s = a | b;
      SEL_SUB: alu_s = a - b;
      SEL_ADD: alu_s = a + b;
      SEL_SLT: alu_s = {{(WIDTH-1){1'b0}}, slt_s};
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (sel)
            SEL_MUL: begin
              state_d = S_MUL;
              cnt_d   = CW'(WIDTH - 1);
              acc_d   = {WIDTH{1'b0}};
              opa_d   = a;
              opb_d   = b;
            end
            SEL_DIV: begin
              if (b == {WIDTH{1'b0}}) begin
                state_d  = S_DONE;
                result_d = {WIDTH{1'b1}};
                zero_d   = 1'b0;
                dbz_d    = 1'b1;
              end else begin
                state_d = S_DIV;
                cnt_d   = CW'(WIDTH - 1);
                acc_d   = {WIDTH{1'b0}};
                opa_d   = a;
                opb_d   = b;
              end
            end
            SEL_NOP: begin
              state_d = S_DONE;
              dbz_d   = 1'b0;
            end
            default: begin
              state_d  = S_DONE;
              result_d = alu_s;
              zero_d   = (alu_s == {WIDTH{1'b0}});
              dbz_d    = 1'b0;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d = mul_sum_s;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        if (cnt_q == {CW{1'b0}}) begin
          state_d  = S_DONE;
          result_d = mul_sum_s;
          zero_d   = (mul_sum_s == {WIDTH{1'b0}});
          dbz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIV: begin
        acc_d = rem_next_s;
        opa_d = quot_next_s;
        if (cnt_q == {CW{1'b0}}) begin
          state_d  = S_DONE;
          result_d = quot_next_s;
          zero_d   = (quot_next_s == {WIDTH{1'b0}});
          dbz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      opa_q    <= {WIDTH{1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result      = result_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Scoreboard bench for alu_iterative_exec: stimulus pushes expected
// completions, a negedge monitor pops and checks them on every done pulse.
module tb_alu_iterative_exec;

  localparam int W = 32;
  localparam logic [2:0] NOP = 3'b000, AND_ = 3'b001, OR_ = 3'b010, SUB = 3'b011;
  localparam logic [2:0] MUL = 3'b100, DIV = 3'b101, ADD = 3'b110, SLT = 3'b111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   sel = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         zero, div_by_zero, busy, done;

  alu_iterative_exec #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .a(a), .b(b),
    .result(result), .zero(zero), .div_by_zero(div_by_zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         dz;
    int           at;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {32'd0, result}, {32'd0, e.res});
        chk("zero", {63'd0, zero}, {63'd0, e.z});
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
        chk("done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic ez, input logic edz,
                       input int lat, input bit push, output int acc);
    exp_t e;
    wait_idle();
    sel = s; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    if (push) begin
      e.res = er; e.z = ez; e.dz = edz; e.at = acc + lat;
      sb.push_back(e);
    end
    start = 1'b0;
    a = $urandom; b = $urandom; sel = $urandom_range(7, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int acc;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);

    issue(ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 0, 1'b1, acc);
    chk("add_busy_hi", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    chk("add_busy_lo", {63'd0, busy}, 64'd0);
    issue(SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 0, 1'b1, acc);
    issue(SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 1'b1, acc);
    issue(SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 0, 1'b1, acc);
    issue(SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 0, 1'b1, acc);
    issue(AND_, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0, 0, 1'b1, acc);
    issue(OR_, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 1'b0, 0, 1'b1, acc);
    issue(NOP, 32'd0, 32'd0, 32'h0000_FFF0, 1'b0, 1'b0, 0, 1'b1, acc);

    // Multiply with stray starts and operand churn during iteration.
    issue(MUL, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0, W, 1'b1, acc);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; sel = ADD; a = $urandom; b = $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("mul_hold_result", {32'd0, result}, 64'h0000_FFF0);
    chk("mul_busy", {63'd0, busy}, 64'd1);
    issue(MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b0, W, 1'b1, acc);
    issue(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, W, 1'b1, acc);

    issue(DIV, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, W, 1'b1, acc);
    issue(DIV, 32'd42, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 1'b1, acc);
    issue(ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 0, 1'b1, acc);
    issue(DIV, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, W, 1'b1, acc);
    issue(DIV, 32'd5, 32'd9, 32'd0, 1'b1, 1'b0, W, 1'b1, acc);
    issue(DIV, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b0, W, 1'b1, acc);

    // Reset lands on the tenth edge after accept; no completion may follow.
    issue(DIV, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0, W, 1'b0, acc);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    chk("rstmid_result", {32'd0, result}, 64'd0);
    chk("rstmid_zero", {63'd0, zero}, 64'd1);
    chk("rstmid_done", {63'd0, done}, 64'd0);
    issue(ADD, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0, 0, 1'b1, acc);
    chk("post_rst_accept", 64'(acc), 64'(cyc));

    // Start held high: accepts every second edge, operands re-latched each time.
    wait_idle();
    sel = ADD; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    n0 = cyc;
    begin
      exp_t e;
      e.res = 32'd7; e.z = 1'b0; e.dz = 1'b0; e.at = n0;
      sb.push_back(e);
      for (int k = 1; k <= 3; k++) begin
        a = 32'(3 + 10 * k);
        @(posedge clk); #1;
        @(posedge clk); #1;
        e.res = 32'(7 + 10 * k); e.at = n0 + 2 * k;
        sb.push_back(e);
      end
    end
    start = 1'b0;

    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("pending_expectations", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
